// File: rtl/led_afterglow_pkg.sv
// Shared definitions for the LED afterglow output stage: default brightness
// width, full-scale brightness helper and the saturating decay subtraction.
package led_pkg;

    localparam int BW_DEFAULT = 8;

    function automatic int unsigned bmax(input int unsigned bw);
        return (32'd1 << bw) - 32'd1;
    endfunction

    // Clamps at zero so a fading LED never wraps back to bright.
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/led_afterglow_ch.sv
// One afterglow channel: brightness register with load/decay update and a
// registered PWM comparator against the shared period counter.
module led_afterglow_ch
    import led_pkg::*;
#(
    parameter int BW         = BW_DEFAULT,
    parameter int DECAY_STEP = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          led_in,
    input  logic          tick,
    input  logic [BW-1:0] pwm_cnt,
    output logic          led_out
);

    localparam logic [BW-1:0] BMAX = BW'(bmax(BW));

    logic [BW-1:0] bright_q, bright_d;
    logic          led_out_q, led_out_d;

    // A live input always wins over a coincident decay tick.
    always_comb begin
        bright_d  = bright_q;
        led_out_d = (bright_q > pwm_cnt);
        if (led_in) begin
            bright_d = BMAX;
        end else if (tick) begin
            bright_d = BW'(sat_sub(32'(bright_q), DECAY_STEP));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q  <= '0;
            led_out_q <= 1'b0;
        end else begin
            bright_q  <= bright_d;
            led_out_q <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: rtl/led_afterglow.sv
// Afterglow PWM output stage: shared PWM period counter and decay prescaler,
// with one brightness channel per LED.
module led_afterglow
    import led_pkg::*;
#(
    parameter int N          = 16,
    parameter int BW         = BW_DEFAULT,
    parameter int DECAY_DIV  = 50000,
    parameter int DECAY_STEP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] led_in,
    output logic [N-1:0] led_out,
    output logic         pwm_wrap
);

    localparam logic [BW-1:0] BMAX  = BW'(bmax(BW));
    // A divider of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int            PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);

    logic [BW-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick;

    assign tick     = (pre_cnt_q == PRE_LAST);
    assign pwm_wrap = (pwm_cnt_q == BMAX - BW'(1));

    always_comb begin
        pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + BW'(1);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            pre_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        led_afterglow_ch #(
            .BW        (BW),
            .DECAY_STEP(DECAY_STEP)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .led_in (led_in[i]),
            .tick   (tick),
            .pwm_cnt(pwm_cnt_q),
            .led_out(led_out[i])
        );
    end

endmodule
